// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing bus.
// Holds the 800x600@60 default mode, the counter type, the colour-bar table
// used by the optional test pattern (VGA_TEST_PATTERN_EN), and a small
// window helper shared by the axis counters.
package vga_pkg;

  // Default mode: 800x600@60 (40 MHz pixel clock)
  localparam int   VGA_CNT_W    = 11;
  localparam int   VGA_RGB_W    = 12;
  localparam int   VGA_H_ACTIVE = 800;
  localparam int   VGA_H_FP     = 40;
  localparam int   VGA_H_SYNC   = 128;
  localparam int   VGA_H_BP     = 88;
  localparam int   VGA_V_ACTIVE = 600;
  localparam int   VGA_V_FP     = 1;
  localparam int   VGA_V_SYNC   = 4;
  localparam int   VGA_V_BP     = 23;
  localparam logic VGA_HS_POL   = 1'b1;
  localparam logic VGA_VS_POL   = 1'b1;

  typedef logic [10:0] vga_cnt_t;

  // Colour bars, 4:4:4 with red in the top nibble. Every channel is either
  // fully on or fully off, so widening to another RGB width only needs the
  // top bit of each nibble.
  localparam logic [11:0] VGA_BAR_TABLE [8] = '{
    12'hFFF,  // white
    12'hFF0,  // yellow
    12'h0FF,  // cyan
    12'h0F0,  // green
    12'hF0F,  // magenta
    12'hF00,  // red
    12'h00F,  // blue
    12'h000   // black
  };

  // True when pos lies in the half-open window [lo, hi)
  function automatic logic vga_in_win(input int pos, input int lo, input int hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one timing axis (horizontal or vertical).
// Counts 0..TOTAL-1 on step, and registers sync/blank from the next count so
// the flags always match the count they are presented with.
// wrap is combinational: high while the count sits on its last position.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int   CNT_W  = VGA_CNT_W,
  parameter int   ACTIVE = VGA_H_ACTIVE,
  parameter int   FP     = VGA_H_FP,
  parameter int   SYNC   = VGA_H_SYNC,
  parameter int   BP     = VGA_H_BP,
  parameter logic POL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             blnk,
  output logic             wrap
);

  localparam int TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_LO = ACTIVE + FP;
  localparam int SYNC_HI = ACTIVE + FP + SYNC;

  logic [CNT_W-1:0] count_nxt;

  assign wrap = (count == CNT_W'(TOTAL - 1));

  // Next position: advance on step, fold back to 0 after the last position
  always_comb begin
    count_nxt = count;
    if (step) count_nxt = wrap ? '0 : count + 1'b1;
  end

  // Count and flags share one register stage, flags decoded from count_nxt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~POL;
    end else begin
      count <= count_nxt;
      blnk  <= (int'(count_nxt) >= ACTIVE);
      sync  <= vga_in_win(int'(count_nxt), SYNC_LO, SYNC_HI) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator at the head of the
// display pipeline. Advances one pixel per clk where pix_en=1; all bus
// outputs are registered and mutually aligned.
// Optional feature macro: VGA_TEST_PATTERN_EN -- when defined, rgb carries
// 8 vertical colour bars in the active area; otherwise rgb is constant 0.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CNT_W    = VGA_CNT_W,
  parameter int   RGB_W    = VGA_RGB_W,
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = VGA_HS_POL,
  parameter logic VS_POL   = VGA_VS_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic             hsync,
  output logic             hblnk,
  output logic [CNT_W-1:0] vcount,
  output logic             vsync,
  output logic             vblnk,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A mode that does not fit the counters would silently alias
  if (H_TOTAL > (1 << CNT_W)) begin : g_h_range
    $fatal(1, "vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_range
    $fatal(1, "vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end

  logic h_wrap;
  logic v_wrap;
  logic v_step;

  // The vertical axis moves one line each time the horizontal axis folds
  assign v_step = pix_en & h_wrap;

  vga_axis_cnt #(
    .CNT_W (CNT_W),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .POL   (HS_POL)
  ) u_h (
    .clk  (clk),
    .rst  (rst),
    .step (pix_en),
    .count(hcount),
    .sync (hsync),
    .blnk (hblnk),
    .wrap (h_wrap)
  );

  vga_axis_cnt #(
    .CNT_W (CNT_W),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .POL   (VS_POL)
  ) u_v (
    .clk  (clk),
    .rst  (rst),
    .step (v_step),
    .count(vcount),
    .sync (vsync),
    .blnk (vblnk),
    .wrap (v_wrap)
  );

  // Pulse in the cycle the bus lands on (0,0) through the frame wrap;
  // leaving reset is not a wrap, so it never fires there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_start <= 1'b0;
    else     frame_start <= pix_en & h_wrap & v_wrap;
  end

`ifdef VGA_TEST_PATTERN_EN

  localparam int CW      = RGB_W / 3;
  localparam int BAR_PIX = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic [RGB_W-1:0] rgb_nxt;
  logic [2:0]       bar_idx;
  int               bar_q;

  // Widen a full-on/full-off 4:4:4 entry to RGB_W, leftover LSBs stay 0
  function automatic logic [RGB_W-1:0] scale_bar(input logic [11:0] c);
    logic [RGB_W-1:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int b = 0; b < CW; b++)
        r[ch*CW + b] = c[ch*4 + 3];
    return r;
  endfunction

  // Next position of the bus, so the colour is registered together with
  // the counters instead of trailing them by a cycle
  always_comb begin
    h_nxt = hcount;
    v_nxt = vcount;
    if (pix_en) begin
      h_nxt = h_wrap ? '0 : hcount + 1'b1;
      if (h_wrap) v_nxt = v_wrap ? '0 : vcount + 1'b1;
    end
  end

  // Bar lookup; a ragged remainder past the 8th bar reuses the last colour
  always_comb begin
    rgb_nxt = '0;
    bar_q   = int'(h_nxt) / BAR_PIX;
    bar_idx = (bar_q > 7) ? 3'd7 : 3'(bar_q);
    if ((int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE))
      rgb_nxt = scale_bar(VGA_BAR_TABLE[bar_idx]);
  end

  // Colour register, blank outside the active area
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb <= '0;
    else     rgb <= rgb_nxt;
  end

`else

  // Image is painted by downstream stages
  assign rgb = '0;

`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generator instances (default 800x600, a tiny
// negative-polarity mode and a small positive-polarity mode) checked every
// cycle against a model that derives the bus from the count of enabled
// pixels since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } mode_t;

  typedef struct {
    int h, v;
    bit hs, hb, vs, vb;
    int rgb;
  } exp_t;

  localparam mode_t MA = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  localparam mode_t MB = '{8, 2, 3, 1, 4, 1, 1, 1, 1'b0, 1'b0};
  localparam mode_t MC = '{16, 2, 3, 2, 6, 2, 2, 3, 1'b1, 1'b1};

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] ha, va;
  logic        hsa, hba, vsa, vba, fsa;
  logic [11:0] rgba;
  logic [3:0]  hb_c, vb_c;
  logic        hsb, hbb, vsb, vbb, fsb;
  logic [11:0] rgbb;
  logic [4:0]  hc, vc;
  logic        hsc, hbc, vsc, vbc, fsc;
  logic [11:0] rgbc;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(ha), .hsync(hsa), .hblnk(hba),
    .vcount(va), .vsync(vsa), .vblnk(vba),
    .rgb(rgba), .frame_start(fsa)
  );

  vga_timing_gen #(
    .CNT_W(4), .RGB_W(12),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(hb_c), .hsync(hsb), .hblnk(hbb),
    .vcount(vb_c), .vsync(vsb), .vblnk(vbb),
    .rgb(rgbb), .frame_start(fsb)
  );

  vga_timing_gen #(
    .CNT_W(5), .RGB_W(12),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_c (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(hc), .hsync(hsc), .hblnk(hbc),
    .vcount(vc), .vsync(vsc), .vblnk(vbc),
    .rgb(rgbc), .frame_start(fsc)
  );

  // ---------------- reference model ----------------
  function automatic int htot(mode_t m);
    return m.ha + m.hf + m.hs + m.hb;
  endfunction

  function automatic int vtot(mode_t m);
    return m.va + m.vf + m.vs + m.vb;
  endfunction

  function automatic longint per(mode_t m);
    return longint'(htot(m)) * longint'(vtot(m));
  endfunction

  // Bus contents after n enabled pixels; st = at least one pixel since reset
  function automatic exp_t model(mode_t m, longint n, bit st);
    exp_t e;
    int   bw, b;
    e.h  = int'(n % longint'(htot(m)));
    e.v  = int'((n / longint'(htot(m))) % longint'(vtot(m)));
    e.hb = (e.h >= m.ha);
    e.vb = (e.v >= m.va);
    e.hs = (e.h >= m.ha + m.hf && e.h < m.ha + m.hf + m.hs) ? m.hp : !m.hp;
    e.vs = (e.v >= m.va + m.vf && e.v < m.va + m.vf + m.vs) ? m.vp : !m.vp;
    e.rgb = 0;
    bw = (m.ha / 8 > 0) ? m.ha / 8 : 1;
    b  = (e.h / bw > 7) ? 7 : e.h / bw;
`ifdef VGA_TEST_PATTERN_EN
    if (st && !e.hb && !e.vb) begin
      case (b)
        0: e.rgb = 'hFFF;
        1: e.rgb = 'hFF0;
        2: e.rgb = 'h0FF;
        3: e.rgb = 'h0F0;
        4: e.rgb = 'hF0F;
        5: e.rgb = 'hF00;
        6: e.rgb = 'h00F;
        default: e.rgb = 'h000;
      endcase
    end
`else
    if (st && b > 99) e.rgb = -1;  // unreachable: bars never exceed 7
`endif
    return e;
  endfunction

  longint na = 0, nb = 0, nc = 0;
  bit     st = 1'b0;
  bit     fea = 1'b0, feb = 1'b0, fec = 1'b0;

  // Model state: enabled-pixel count per instance and expected frame pulse
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      na <= 0; nb <= 0; nc <= 0; st <= 1'b0;
      fea <= 1'b0; feb <= 1'b0; fec <= 1'b0;
    end else if (pix_en) begin
      na <= na + 1; nb <= nb + 1; nc <= nc + 1; st <= 1'b1;
      fea <= ((na + 1) % per(MA)) == 0;
      feb <= ((nb + 1) % per(MB)) == 0;
      fec <= ((nc + 1) % per(MC)) == 0;
    end else begin
      fea <= 1'b0; feb <= 1'b0; fec <= 1'b0;
    end
  end

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(string t, mode_t m, longint n, bit s, bit fe,
                     int h, int v, bit hs, bit hb, bit vs, bit vb,
                     int rgb, bit fs);
    exp_t e;
    e = model(m, n, s);
    chk({t, ".hcount"}, h, e.h);
    chk({t, ".vcount"}, v, e.v);
    chk({t, ".hsync"}, hs, e.hs);
    chk({t, ".hblnk"}, hb, e.hb);
    chk({t, ".vsync"}, vs, e.vs);
    chk({t, ".vblnk"}, vb, e.vb);
    chk({t, ".rgb"}, rgb, e.rgb);
    chk({t, ".frame_start"}, fs, fe);
  endtask

  // Compare process: every falling edge, all three instances
  always @(negedge clk) begin
    cmp("A", MA, na, st, fea, 32'(ha), 32'(va), hsa, hba, vsa, vba, 32'(rgba), fsa);
    cmp("B", MB, nb, st, feb, 32'(hb_c), 32'(vb_c), hsb, hbb, vsb, vbb, 32'(rgbb), fsb);
    cmp("C", MC, nc, st, fec, 32'(hc), 32'(vc), hsc, hbc, vsc, vbc, 32'(rgbc), fsc);
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    bit   found;

    // Hand-computed points that pin the model itself
    e = model(MA, 799, 1);  chk("pin.A.hblnk799", e.hb, 0);
    e = model(MA, 800, 1);  chk("pin.A.hblnk800", e.hb, 1);
    e = model(MA, 839, 1);  chk("pin.A.hsync839", e.hs, 0);
    e = model(MA, 840, 1);  chk("pin.A.hsync840", e.hs, 1);
    e = model(MA, 967, 1);  chk("pin.A.hsync967", e.hs, 1);
    e = model(MA, 968, 1);  chk("pin.A.hsync968", e.hs, 0);
    e = model(MA, 1056, 1); chk("pin.A.wrap_h", e.h, 0); chk("pin.A.wrap_v", e.v, 1);
    e = model(MA, 1056*600, 1); chk("pin.A.vblnk600", e.vb, 1); chk("pin.A.vsync600", e.vs, 0);
    e = model(MA, 1056*601, 1); chk("pin.A.vsync601", e.vs, 1);
    e = model(MA, 1056*604, 1); chk("pin.A.vsync604", e.vs, 1);
    e = model(MA, 1056*605, 1); chk("pin.A.vsync605", e.vs, 0);
    chk("pin.A.period", per(MA), 663168);
    e = model(MB, 10, 1); chk("pin.B.hsync10", e.hs, 0);
    e = model(MB, 12, 1); chk("pin.B.hsync12", e.hs, 0);
    e = model(MB, 13, 1); chk("pin.B.hsync13", e.hs, 1);
    e = model(MB, 70, 1); chk("pin.B.vsync5", e.vs, 0); chk("pin.B.v5", e.v, 5);
    chk("pin.B.period", per(MB), 98);
`ifdef VGA_TEST_PATTERN_EN
    e = model(MA, 99, 1);  chk("pin.A.rgb99", e.rgb, 'hFFF);
    e = model(MA, 100, 1); chk("pin.A.rgb100", e.rgb, 'hFF0);
    e = model(MA, 799, 1); chk("pin.A.rgb799", e.rgb, 'h000);
    e = model(MA, 800, 1); chk("pin.A.rgb800", e.rgb, 0);
`else
    e = model(MA, 100, 1); chk("pin.A.rgb100", e.rgb, 0);
`endif

    // Hold in reset, then leave reset with pix_en low: nothing moves
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Continuous pixels through two full lines of the default mode
    #1 pix_en = 1'b1;
    repeat (2 * 1056 + 100) @(negedge clk);

    // Asynchronous reset mid-line at hcount=500
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      @(negedge clk);
      if (ha == 11'd500) found = 1'b1;
    end
    chk("reach_h500", 32'(found), 1);
    #1 rst = 1'b1;
    #1;
    chk("async.A.hcount", 32'(ha), 0);
    chk("async.A.vcount", 32'(va), 0);
    chk("async.A.hsync", hsa, 0);
    chk("async.A.vsync", vsa, 0);
    chk("async.A.hblnk", hba, 0);
    chk("async.A.vblnk", vba, 0);
    chk("async.A.rgb", 32'(rgba), 0);
    chk("async.A.frame_start", fsa, 0);
    chk("async.B.hsync", hsb, 1);
    chk("async.B.vsync", vsb, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst.A.hcount", 32'(ha), 1);

    // Pixel strobe every second clock
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      #1 pix_en = i[0];
    end

    // Random strobe density
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      #1 pix_en = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
